// File: rtl/fp_mul_round_if.sv
// rtl/fp_mul_round_if.sv - product-in / rounded-result-out handshake bundle for fp_mul_round
interface fp_mul_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sgn_Z;
  logic [9:0]  exp_sum;
  logic [47:0] frc_Z_full;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;

  modport master (
    output in_valid, sgn_Z, exp_sum, frc_Z_full, is_nan, is_inf, is_zero, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );

  modport slave (
    input  in_valid, sgn_Z, exp_sum, frc_Z_full, is_nan, is_inf, is_zero, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );
endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - binary32 multiplier back end: S1 normalize, S2 round/pack, FTZ underflow
// FP_MUL_RND_RMM_EN enables round-to-nearest-ties-away for r_mode=100 (otherwise it rounds as RNE).
module fp_mul_round (
  input  logic          clk,
  input  logic          rst,
  fp_mul_round_if.slave bus
);
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
`ifdef FP_MUL_RND_RMM_EN
  localparam logic [2:0] RM_RMM = 3'b100;
`endif

  logic               v1, v2, ld1, ld2;
  logic               s1_sgn, s1_guard, s1_sticky, s1_nan, s1_inf, s1_zero;
  logic signed [11:0] s1_exp;
  logic [22:0]        s1_mant;
  logic [2:0]         s1_rm;
  logic [31:0]        fp_q;
  logic               ovrf_q, udrf_q;

  logic [22:0]        n_mant;
  logic               n_guard, n_sticky;
  logic signed [11:0] n_exp;

  logic               inc, to_inf, r_ovf, r_udf;
  logic [23:0]        r_sum;
  logic signed [11:0] r_exp;
  logic [31:0]        z_fp;
  logic               z_ovf, z_udf;

  assign ld2          = v1 && (!v2 || bus.out_ready);
  assign bus.in_ready = !v1 || !v2 || bus.out_ready;
  assign ld1          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = v2;
  assign bus.fp_Z     = fp_q;
  assign bus.ovrf     = ovrf_q;
  assign bus.udrf     = udrf_q;

  // Product lies in [1,4); a set bit 47 means one extra binade.
  always_comb begin
    n_mant   = bus.frc_Z_full[45:23];
    n_guard  = bus.frc_Z_full[22];
    n_sticky = |bus.frc_Z_full[21:0];
    n_exp    = {{2{bus.exp_sum[9]}}, bus.exp_sum};
    if (bus.frc_Z_full[47]) begin
      n_mant   = bus.frc_Z_full[46:24];
      n_guard  = bus.frc_Z_full[23];
      n_sticky = |bus.frc_Z_full[22:0];
      n_exp    = {{2{bus.exp_sum[9]}}, bus.exp_sum} + 12'sd1;
    end
  end

  always_comb begin
    case (s1_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sgn && (s1_guard || s1_sticky);
      RM_RUP:  inc = !s1_sgn && (s1_guard || s1_sticky);
`ifdef FP_MUL_RND_RMM_EN
      RM_RMM:  inc = s1_guard;
`endif
      default: inc = s1_guard && (s1_sticky || s1_mant[0]);
    endcase

    case (s1_rm)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s1_sgn;
      RM_RUP:  to_inf = !s1_sgn;
      default: to_inf = 1'b1;
    endcase

    // A carry out of the mantissa leaves zeros in [22:0] and bumps the exponent.
    r_sum = {1'b0, s1_mant} + {23'd0, inc};
    r_exp = s1_exp + {11'd0, r_sum[23]};
    r_ovf = (r_exp >= 12'sd255);
    r_udf = (r_exp <= 12'sd0);

    z_fp  = {s1_sgn, r_exp[7:0], r_sum[22:0]};
    z_ovf = 1'b0;
    z_udf = 1'b0;
    if (s1_nan) begin
      z_fp = 32'h7FC0_0000;
    end else if (s1_inf) begin
      z_fp = {s1_sgn, 8'hFF, 23'd0};
    end else if (s1_zero) begin
      z_fp = {s1_sgn, 31'd0};
    end else if (r_ovf) begin
      z_ovf = 1'b1;
      z_fp  = to_inf ? {s1_sgn, 8'hFF, 23'd0} : {s1_sgn, 8'hFE, 23'h7F_FFFF};
    end else if (r_udf) begin
      z_udf = 1'b1;
      z_fp  = {s1_sgn, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_rm     <= '0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      fp_q      <= '0;
      ovrf_q    <= 1'b0;
      udrf_q    <= 1'b0;
    end else begin
      if (ld1) begin
        v1        <= 1'b1;
        s1_sgn    <= bus.sgn_Z;
        s1_exp    <= n_exp;
        s1_mant   <= n_mant;
        s1_guard  <= n_guard;
        s1_sticky <= n_sticky;
        s1_rm     <= bus.r_mode;
        s1_nan    <= bus.is_nan;
        s1_inf    <= bus.is_inf;
        s1_zero   <= bus.is_zero;
      end else if (ld2) begin
        v1 <= 1'b0;
      end

      if (ld2) begin
        v2     <= 1'b1;
        fp_q   <= z_fp;
        ovrf_q <= z_ovf;
        udrf_q <= z_udf;
      end else if (bus.out_ready) begin
        v2 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_round.sv
// tb/tb_fp_mul_round.sv - directed + scoreboard bench for fp_mul_round
module tb_fp_mul_round;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_round_if bus ();
  fp_mul_round dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [47:0] frc;
    logic [9:0]  es;
    logic        sg;
    logic [2:0]  rm;
    logic        nan, inf, zero;
    logic [31:0] fp;
    logic        ov, ud;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pop_cnt = 0;
  logic [33:0] sbq[$];
  vec_t vecs[15];

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Value-level rounding: compare the discarded remainder against half an ulp.
  function automatic logic [33:0] model(input logic [47:0] frc, input logic [9:0] es, input logic sg,
                                        input logic [2:0] rm, input logic nan, input logic inf, input logic zero);
    longint unsigned m, rem, half;
    int sh, e, erm;
    bit up, ovf, to_inf;
    if (nan)  return {2'b00, 32'h7FC00000};
    if (inf)  return {2'b00, sg, 8'hFF, 23'd0};
    if (zero) return {2'b00, sg, 31'd0};
    erm = int'(rm);
    if (erm > 4) erm = 0;
`ifndef FP_MUL_RND_RMM_EN
    if (erm == 4) erm = 0;
`endif
    sh   = frc[47] ? 24 : 23;
    m    = 64'(frc) >> sh;
    rem  = 64'(frc) & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    e    = $signed(es) + (frc[47] ? 1 : 0);
    case (erm)
      1:       up = 0;
      2:       up = sg && (rem != 0);
      3:       up = !sg && (rem != 0);
      4:       up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && m[0]);
    endcase
    m = m + (up ? 1 : 0);
    if (m >= (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) begin
      to_inf = (erm == 0) || (erm == 4) || (erm == 2 && sg) || (erm == 3 && !sg);
      ovf = 1;
      return {ovf, 1'b0, to_inf ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF}};
    end
    if (e <= 0) return {2'b01, sg, 31'd0};
    return {2'b00, sg, e[7:0], m[22:0]};
  endfunction

  // Scoreboard: push on every accepted product, pop on every delivered result.
  logic        stall = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    logic [33:0] exp_r;
    if (rst) begin
      sbq.delete();
      stall = 1'b0;
    end else begin
      if (stall)
        check("hold", {bus.out_valid, bus.ovrf, bus.udrf, bus.fp_Z} == held,
              64'({bus.out_valid, bus.ovrf, bus.udrf, bus.fp_Z}), 64'(held));
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", sbq.size() != 0, 64'(sbq.size()), 64'd1);
        if (sbq.size() != 0) begin
          exp_r = sbq.pop_front();
          pop_cnt++;
          check("sb_result", {bus.ovrf, bus.udrf, bus.fp_Z} == exp_r,
                64'({bus.ovrf, bus.udrf, bus.fp_Z}), 64'(exp_r));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sbq.push_back(model(bus.frc_Z_full, bus.exp_sum, bus.sgn_Z, bus.r_mode,
                            bus.is_nan, bus.is_inf, bus.is_zero));
      stall = bus.out_valid && !bus.out_ready;
      held  = {1'b1, bus.ovrf, bus.udrf, bus.fp_Z};
    end
  end

  task automatic apply(input vec_t v);
    bus.frc_Z_full = v.frc;
    bus.exp_sum    = v.es;
    bus.sgn_Z      = v.sg;
    bus.r_mode     = v.rm;
    bus.is_nan     = v.nan;
    bus.is_inf     = v.inf;
    bus.is_zero    = v.zero;
  endtask

  task automatic run_one(input int idx);
    int n, lat;
    bit hs;
    @(posedge clk); #1;
    apply(vecs[idx]);
    bus.in_valid = 1'b1;
    hs = 0;
    n = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("accept[%0d]", idx), hs, 64'(hs), 64'd1);
    if (!hs) return;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 10);
    check($sformatf("latency[%0d]", idx), lat == 2, 64'(lat), 64'd2);
    check($sformatf("fp_Z[%0d]", idx), bus.fp_Z == vecs[idx].fp, 64'(bus.fp_Z), 64'(vecs[idx].fp));
    check($sformatf("flags[%0d]", idx), {bus.ovrf, bus.udrf} == {vecs[idx].ov, vecs[idx].ud},
          64'({bus.ovrf, bus.udrf}), 64'({vecs[idx].ov, vecs[idx].ud}));
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    int e;
    r = {$urandom(), $urandom()};
    if (!r[47]) r[46] = 1'b1;
    e = int'($urandom_range(0, 300)) - 20;
    bus.frc_Z_full = r[47:0];
    bus.exp_sum    = e[9:0];
    bus.sgn_Z      = 1'($urandom_range(0, 1));
    bus.r_mode     = 3'($urandom_range(0, 7));
    bus.is_nan     = ($urandom_range(0, 15) == 0);
    bus.is_inf     = ($urandom_range(0, 15) == 0);
    bus.is_zero    = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    int acc, k, n, pops0, sent;
    bit hs, take;
    vecs[0]  = '{48'h900000000000, 10'd127, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0};
    vecs[1]  = '{48'h400000400000, 10'd127, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[2]  = '{48'h400000400000, 10'd127, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
    vecs[3]  = '{48'h400000400000, 10'd127, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'hBF800001, 1'b0, 1'b0};
    vecs[4]  = '{48'h800000000000, 10'd254, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[5]  = '{48'h800000000000, 10'd254, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0};
    vecs[6]  = '{48'h400000000000, 10'd0,   1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[7]  = '{48'h400000000000, 10'd0,   1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{48'h400000000000, 10'd0,   1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b0};
`ifdef FP_MUL_RND_RMM_EN
    vecs[9]  = '{48'h400000400000, 10'd127, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0};
`else
    vecs[9]  = '{48'h400000400000, 10'd127, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
`endif
    vecs[10] = '{48'hFFFFFF800000, 10'd127, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40800000, 1'b0, 1'b0};
    vecs[11] = '{48'h800000000000, 10'd254, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0};
    vecs[12] = '{48'h900000000000, 10'd127, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 32'hFF800000, 1'b0, 1'b0};
    vecs[13] = '{48'h400000400000, 10'd127, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    vecs[14] = '{48'h400000400000, 10'd127, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    apply(vecs[0]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
    check("rst_fp_Z", bus.fp_Z == 32'd0, 64'(bus.fp_Z), 64'd0);
    check("rst_flags", {bus.ovrf, bus.udrf} == 2'b00, 64'({bus.ovrf, bus.udrf}), 64'd0);
    check("rst_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 15; i++)
      check($sformatf("model_pin[%0d]", i),
            model(vecs[i].frc, vecs[i].es, vecs[i].sg, vecs[i].rm, vecs[i].nan, vecs[i].inf, vecs[i].zero)
              == {vecs[i].ov, vecs[i].ud, vecs[i].fp},
            64'(model(vecs[i].frc, vecs[i].es, vecs[i].sg, vecs[i].rm, vecs[i].nan, vecs[i].inf, vecs[i].zero)),
            64'({vecs[i].ov, vecs[i].ud, vecs[i].fp}));

    for (int i = 0; i < 15; i++) run_one(i);

    // Backpressure: three products offered against a stalled sink.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    pops0 = pop_cnt;
    acc = 0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      apply(vecs[k == 0 ? 0 : (k == 1 ? 2 : 10)]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk); #1;
      if (hs) begin
        acc++;
        k++;
      end
    end
    check("bp_accepted", acc == 2, 64'(acc), 64'd2);
    @(negedge clk);
    check("bp_in_ready_low", bus.in_ready == 1'b0, 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    hs = 0;
    n = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("bp_third_accepted", hs, 64'(hs), 64'd1);
    repeat (6) @(negedge clk);
    check("bp_delivered", pop_cnt - pops0 == 3, 64'(pop_cnt - pops0), 64'd3);

    // Reset while stalled with a full pipeline.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    apply(vecs[4]);
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_full", bus.out_valid == 1'b1, 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);
    check("midrst_fp_Z", {bus.ovrf, bus.udrf, bus.fp_Z} == 34'd0, 64'({bus.ovrf, bus.udrf, bus.fp_Z}), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'd1);
    check("midrst_no_ghost", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'd0);

    // Random traffic with random backpressure; the scoreboard does the checking.
    sent = 0;
    take = 1;
    for (int c = 0; c < 3000 && sent < 40; c++) begin
      @(posedge clk); #1;
      if (take) begin
        rand_inputs();
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      take = bus.in_ready;
      if (take) sent++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("rand_sent", sent == 40, 64'(sent), 64'd40);
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sbq.size() == 0, 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fp_mul_round.md
FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 Parameters: none; the module is fixed to IEEE-754 binary32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  upstream multiplier presents a product.
REQ-005 in_ready  out  1  stage can accept a product this cycle.
REQ-006 sgn_Z  in  1  result sign, sgn_X XOR sgn_Y.
REQ-007 exp_sum  in  10  signed two's-complement biased exponent, eX+eY-127.
REQ-008 frc_Z_full  in  48  product of 1.frc_X by 1.frc_Y; binary point between bits 46 and 45.
REQ-009 is_nan / is_inf / is_zero  in  1 each  upstream special-case flags.
REQ-010 r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other values behave as RNE.
REQ-011 out_valid  out  1  fp_Z/ovrf/udrf valid.
REQ-012 out_ready  in  1  downstream accepts the result.
REQ-013 fp_Z  out  32  rounded, packed result.
REQ-014 ovrf / udrf  out  1 each  overflow / underflow flags, qualified by out_valid.

Function
REQ-015 The block is a two-stage pipeline: S1 normalizes, S2 rounds and packs. Latency is exactly 2 cycles from the in_valid&&in_ready handshake to out_valid with no backpressure.
REQ-016 Each stage loads when it is empty or its contents leave in the same cycle; in_ready = !v1 || !v2 || out_ready.
REQ-017 While out_valid && !out_ready, fp_Z, ovrf and udrf hold stable. Results leave in acceptance order and are never dropped or duplicated.
REQ-018 S1 normalization with frc_Z_full[47]=1: mant=[46:24], guard=[23], sticky=|[22:0], exp=exp_sum+1.
REQ-019 S1 normalization with frc_Z_full[47]=0: mant=[45:23], guard=[22], sticky=|[21:0], exp=exp_sum.
REQ-020 Round increment:
  - RNE: guard && (sticky || mant[0]).
  - RTZ: 0.
  - RDN: sgn && (guard || sticky).
  - RUP: !sgn && (guard || sticky).
  - RMM: guard.
REQ-021 If the mantissa increment carries out (all ones + 1), mant becomes 0 and exp increments by 1.
REQ-022 Overflow is final exp >= 255, which sets ovrf=1.
  - Result is signed infinity for RNE and RMM, for RUP when positive, and for RDN when negative.
  - Otherwise the result is signed max finite (exponent 0xFE, mantissa all ones).
REQ-023 Underflow is final exp <= 0. fp_Z is signed zero (flush-to-zero, no subnormal output) and udrf=1.
REQ-024 Special-case priority is nan > inf > zero > normal path.
  - nan: fp_Z=0x7FC00000.
  - inf: fp_Z = {sgn_Z, 0xFF, 0}.
  - zero: fp_Z = {sgn_Z, 31'b0}.
  - ovrf=udrf=0 in all three cases.
REQ-025 r_mode is sampled at the input handshake and travels with its data through the pipeline.

Reset
REQ-026 rst=1 at a clock edge clears v1, v2 and out_valid, and sets fp_Z=0, ovrf=0, udrf=0.
REQ-027 rst mid-operation discards all in-flight results; in_ready=1 in the first cycle after reset is released.
REQ-028 No output depends on uninitialized state after reset.

Configuration
REQ-029 Macro FP_MUL_RND_RMM_EN.
  - Defined: r_mode=100 performs round-to-nearest, ties-away as in REQ-020.
  - Undefined: r_mode=100 behaves exactly as RNE, and the RMM logic is not compiled.

Verification
REQ-030 frc_Z_full=0x900000000000, exp_sum=127, sgn_Z=0, RNE -> fp_Z=0x40100000, ovrf=udrf=0, out_valid exactly 2 cycles after the handshake.
REQ-031 frc_Z_full=0x400000400000 (tie), exp_sum=127:
  - RNE -> 0x3F800000.
  - RUP -> 0x3F800001.
  - RDN with sgn_Z=1 -> 0xBF800001.
REQ-032 frc_Z_full=0x800000000000, exp_sum=254:
  - RNE -> 0x7F800000, ovrf=1.
  - RTZ -> 0x7F7FFFFF, ovrf=1.
REQ-033 frc_Z_full=0x400000000000, exp_sum=0:
  - sgn_Z=0 -> 0x00000000, udrf=1.
  - sgn_Z=1 -> 0x80000000, udrf=1.
  - is_nan=1 with any data -> 0x7FC00000.
REQ-034 Backpressure: out_ready=0 for 5 cycles while 3 products are offered.
  - Exactly 2 are accepted, then in_ready=0.
  - fp_Z stays stable.
  - After out_ready=1, all 3 results arrive in order.
  - Asserting rst mid-stall gives out_valid=0 on the next cycle.
REQ-035 Tie from REQ-031 with r_mode=100:
  - FP_MUL_RND_RMM_EN defined -> 0x3F800001.
  - FP_MUL_RND_RMM_EN undefined -> 0x3F800000.
